// File: rtl/im_fetch_cache.sv
// Direct-mapped, one-word-per-line instruction cache in front of the MEM instruction port.
// Holds off fetches until boot copy completes and keeps saturating hit/miss counters.
`timescale 1ns/1ps
module im_fetch_cache #(
  parameter int unsigned LINES  = 16,
  parameter int unsigned ADDR_W = 22
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              start,
  input  logic              flush,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_rdy,
  output logic [31:0]       cpu_data,
  output logic              im_work,
  output logic [ADDR_W-1:0] im_addr,
  input  logic [31:0]       im_dataout,
  input  logic              en,
  output logic [15:0]       hit_cnt,
  output logic [15:0]       miss_cnt
);

  localparam int unsigned IDX_W  = $clog2(LINES);
  localparam int unsigned TAG_W  = ADDR_W - IDX_W;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t              state_q, state_d;
  logic [LINES-1:0]    valid_q, valid_d;
  logic                flush_pend_q, flush_pend_d;
  logic                cpu_rdy_d, im_work_d;
  logic [DATA_W-1:0]   cpu_data_d;
  logic [ADDR_W-1:0]   im_addr_d;
  logic [CNT_W-1:0]    hit_cnt_d, miss_cnt_d;
  logic                fill_we;

  logic [TAG_W-1:0]    tag_ram  [LINES];
  logic [DATA_W-1:0]   data_ram [LINES];

  logic [IDX_W-1:0]    req_idx, fill_idx;
  logic [TAG_W-1:0]    req_tag, fill_tag;
  logic                hit;

  assign req_idx  = cpu_addr[IDX_W-1:0];
  assign req_tag  = cpu_addr[ADDR_W-1:IDX_W];
  assign fill_idx = im_addr[IDX_W-1:0];
  assign fill_tag = im_addr[ADDR_W-1:IDX_W];
  assign hit      = valid_q[req_idx] && (tag_ram[req_idx] == req_tag);

  // Next-state and next-output logic; everything defaults to holding its value.
  always_comb begin
    state_d      = state_q;
    valid_d      = valid_q;
    flush_pend_d = flush_pend_q;
    cpu_rdy_d    = cpu_rdy;
    cpu_data_d   = cpu_data;
    im_work_d    = im_work;
    im_addr_d    = im_addr;
    hit_cnt_d    = hit_cnt;
    miss_cnt_d   = miss_cnt;
    fill_we      = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          valid_d = '0;
        end else if (start && cpu_req && hit) begin
          cpu_data_d = data_ram[req_idx];
          cpu_rdy_d  = 1'b1;
          hit_cnt_d  = (hit_cnt == '1) ? hit_cnt : hit_cnt + CNT_W'(1);
          state_d    = DONE;
        end else if (start && cpu_req) begin
          im_work_d  = 1'b1;
          im_addr_d  = cpu_addr;
          miss_cnt_d = (miss_cnt == '1) ? miss_cnt : miss_cnt + CNT_W'(1);
          state_d    = FILL;
        end
      end
      FILL: begin
        if (flush) flush_pend_d = 1'b1;
        if (en) begin
          cpu_data_d = im_dataout;
          cpu_rdy_d  = 1'b1;
          im_work_d  = 1'b0;
          state_d    = DONE;
          // A flush seen anywhere in the fill makes the returned word stale for caching.
          if (!flush_pend_q && !flush) begin
            fill_we           = 1'b1;
            valid_d[fill_idx] = 1'b1;
          end else begin
            valid_d      = '0;
            flush_pend_d = 1'b0;
          end
        end
      end
      DONE: begin
        cpu_rdy_d = 1'b0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      flush_pend_q <= 1'b0;
      cpu_rdy      <= 1'b0;
      cpu_data     <= '0;
      im_work      <= 1'b0;
      im_addr      <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      flush_pend_q <= flush_pend_d;
      cpu_rdy      <= cpu_rdy_d;
      cpu_data     <= cpu_data_d;
      im_work      <= im_work_d;
      im_addr      <= im_addr_d;
      hit_cnt      <= hit_cnt_d;
      miss_cnt     <= miss_cnt_d;
    end
  end

  // Tag/data storage carries no reset; valid bits alone qualify contents.
  always_ff @(posedge clk_in) begin
    if (fill_we) begin
      tag_ram[fill_idx]  <= fill_tag;
      data_ram[fill_idx] <= im_dataout;
    end
  end

endmodule

// File: tb/tb_im_fetch_cache.sv
// Directed self-checking bench for im_fetch_cache: misses, hits, conflicts, flush, boot gating,
// reset mid-fill and counter saturation.
`timescale 1ns/1ps
module tb_im_fetch_cache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start;
  logic        flush;
  logic        cpu_req;
  logic [21:0] cpu_addr;
  logic        cpu_rdy;
  logic [31:0] cpu_data;
  logic        im_work;
  logic [21:0] im_addr;
  logic [31:0] im_dataout;
  logic        en;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  int total = 0;
  int bad   = 0;

  im_fetch_cache #(.LINES(16), .ADDR_W(22)) dut (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .start      (start),
    .flush      (flush),
    .cpu_req    (cpu_req),
    .cpu_addr   (cpu_addr),
    .cpu_rdy    (cpu_rdy),
    .cpu_data   (cpu_data),
    .im_work    (im_work),
    .im_addr    (im_addr),
    .im_dataout (im_dataout),
    .en         (en),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk_in);
  endtask

  // Miss: MEM answers lat cycles after im_work is seen; optional flush pulse mid-fill.
  task automatic miss_fetch(input logic [21:0] addr, input logic [31:0] data,
                            input int lat, input bit fl);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    step;
    check("miss_work", 32'(im_work), 32'd1);
    check("miss_addr", 32'(im_addr), 32'(addr));
    check("miss_rdy_low", 32'(cpu_rdy), 32'd0);
    for (int i = 0; i < lat - 1; i++) begin
      flush = fl && (i == 0);
      step;
      flush = 1'b0;
      check("fill_work", 32'(im_work), 32'd1);
      check("fill_addr", 32'(im_addr), 32'(addr));
    end
    en         = 1'b1;
    im_dataout = data;
    step;
    en         = 1'b0;
    im_dataout = '0;
    check("miss_rdy", 32'(cpu_rdy), 32'd1);
    check("miss_data", cpu_data, data);
    check("miss_work_drop", 32'(im_work), 32'd0);
    cpu_req = 1'b0;
    step;
    check("miss_rdy_pulse", 32'(cpu_rdy), 32'd0);
    check("miss_no_rework", 32'(im_work), 32'd0);
  endtask

  task automatic hit_fetch(input logic [21:0] addr, input logic [31:0] data);
    cpu_req  = 1'b1;
    cpu_addr = addr;
    step;
    check("hit_rdy", 32'(cpu_rdy), 32'd1);
    check("hit_data", cpu_data, data);
    check("hit_no_work", 32'(im_work), 32'd0);
    cpu_req = 1'b0;
    step;
    check("hit_rdy_pulse", 32'(cpu_rdy), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_in = 1'b0; start = 1'b0; flush = 1'b0; cpu_req = 1'b0;
    cpu_addr = '0; im_dataout = '0; en = 1'b0;
    step; step;
    check("rst_rdy", 32'(cpu_rdy), 32'd0);
    check("rst_data", cpu_data, 32'd0);
    check("rst_work", 32'(im_work), 32'd0);
    check("rst_addr", 32'(im_addr), 32'd0);
    check("rst_hit", 32'(hit_cnt), 32'd0);
    check("rst_miss", 32'(miss_cnt), 32'd0);
    rst_in = 1'b1;
    step;
    start = 1'b1;

    // Cold miss then hit
    miss_fetch(22'h000005, 32'hDEADBEEF, 3, 1'b0);
    check("t1_miss_cnt", 32'(miss_cnt), 32'd1);
    check("t1_hit_cnt", 32'(hit_cnt), 32'd0);
    hit_fetch(22'h000005, 32'hDEADBEEF);
    check("t2_hit_cnt", 32'(hit_cnt), 32'd1);

    // Conflict on index 5
    miss_fetch(22'h000015, 32'h11111111, 2, 1'b0);
    miss_fetch(22'h000005, 32'h33333333, 2, 1'b0);
    check("t3_miss_cnt", 32'(miss_cnt), 32'd3);
    hit_fetch(22'h000005, 32'h33333333);
    check("t3_hit_cnt", 32'(hit_cnt), 32'd2);

    // Flush during fill: word delivered, nothing left valid
    miss_fetch(22'h000007, 32'h22222222, 3, 1'b1);
    miss_fetch(22'h000005, 32'h44444444, 1, 1'b0);
    miss_fetch(22'h000007, 32'h55555555, 1, 1'b0);
    check("t4_miss_cnt", 32'(miss_cnt), 32'd6);
    hit_fetch(22'h000007, 32'h55555555);
    check("t4_hit_cnt", 32'(hit_cnt), 32'd3);

    // Flush in IDLE beats a pending request and invalidates
    flush = 1'b1; cpu_req = 1'b1; cpu_addr = 22'h000007;
    step;
    check("idle_flush_rdy", 32'(cpu_rdy), 32'd0);
    check("idle_flush_work", 32'(im_work), 32'd0);
    flush = 1'b0; cpu_req = 1'b0;
    step;
    miss_fetch(22'h000007, 32'h66666666, 1, 1'b0);
    check("flush_miss_cnt", 32'(miss_cnt), 32'd7);
    check("flush_hit_keep", 32'(hit_cnt), 32'd3);

    // Boot gating, at the top address
    start = 1'b0; cpu_req = 1'b1; cpu_addr = 22'h3FFFFF;
    for (int i = 0; i < 10; i++) begin
      step;
      check("gate_work", 32'(im_work), 32'd0);
      check("gate_rdy", 32'(cpu_rdy), 32'd0);
    end
    start = 1'b1;
    step;
    check("gate_release_work", 32'(im_work), 32'd1);
    check("gate_release_addr", 32'(im_addr), 32'h003FFFFF);
    en = 1'b1; im_dataout = 32'hA5A5A5A5;
    step;
    en = 1'b0; im_dataout = '0;
    check("gate_rdy_done", 32'(cpu_rdy), 32'd1);
    check("gate_data", cpu_data, 32'hA5A5A5A5);
    cpu_req = 1'b0;
    step;
    check("gate_miss_cnt", 32'(miss_cnt), 32'd8);
    hit_fetch(22'h3FFFFF, 32'hA5A5A5A5);
    check("top_hit_cnt", 32'(hit_cnt), 32'd4);

    // Reset mid-fill
    cpu_req = 1'b1; cpu_addr = 22'h000000;
    step;
    check("rf_work", 32'(im_work), 32'd1);
    #2 rst_in = 1'b0;
    #1;
    check("rf_work_drop", 32'(im_work), 32'd0);
    check("rf_hit", 32'(hit_cnt), 32'd0);
    check("rf_miss", 32'(miss_cnt), 32'd0);
    check("rf_rdy", 32'(cpu_rdy), 32'd0);
    cpu_req = 1'b0;
    step;
    rst_in = 1'b1;
    step;
    en = 1'b1; im_dataout = 32'hBAADF00D;
    step;
    en = 1'b0; im_dataout = '0;
    check("late_en_rdy", 32'(cpu_rdy), 32'd0);
    check("late_en_data", cpu_data, 32'd0);
    step;
    miss_fetch(22'h000005, 32'h77777777, 1, 1'b0);
    check("rf_post_miss", 32'(miss_cnt), 32'd1);

    // Saturation: preload near the top, then hit past it
    force dut.hit_cnt = 16'hFFFE;
    step;
    release dut.hit_cnt;
    check("sat_preload", 32'(hit_cnt), 32'h0000FFFE);
    hit_fetch(22'h000005, 32'h77777777);
    check("sat_first", 32'(hit_cnt), 32'h0000FFFF);
    hit_fetch(22'h000005, 32'h77777777);
    check("sat_stick", 32'(hit_cnt), 32'h0000FFFF);
    check("sat_miss_keep", 32'(miss_cnt), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
